register_file: RTL and testbench

32-entry × 64-bit general-purpose register file for the 64-bit single-cycle datapath, sitting between instruction decode and the ALU. It has two combinational read ports (A, B) and one write port committed on the falling clock edge. Register 31 is the hardwired zero register (XZR). An asynchronous active-low reset clears the array.

---
 rtl/register_file.sv | 62 ++++++
 tb/tb_register_file.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// register_file
//   32 x 64-bit general-purpose register file. Entries 0-30 are storage;
//   entry 31 is the hardwired zero register and has no flops.
//   Two combinational read ports, one write port that commits on the
//   falling edge of Clk. Async active-low reset clears all storage.
// Ports
//   Clk    in   1   clock, writes commit on falling edge
//   Rst_n  in   1   async active-low reset
//   RA     in   5   read address, port A
//   RB     in   5   read address, port B
//   RW     in   5   write address
//   BusW   in  64   write data
//   RegWr  in   1   write enable
//   BusA   out 64   read data for RA (combinational)
//   BusB   out 64   read data for RB (combinational)
`timescale 1ns/1ps
module register_file (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [4:0]  RA,
  input  logic [4:0]  RB,
  input  logic [4:0]  RW,
  input  logic [63:0] BusW,
  input  logic        RegWr,
  output logic [63:0] BusA,
  output logic [63:0] BusB
);

  localparam int NUM_REGS = 31;   // storage entries; index 31 is XZR
  localparam int REG_W    = 64;

  logic [NUM_REGS-1:0][REG_W-1:0] r_regs;
  logic [REG_W-1:0]               w_rd_a;
  logic [REG_W-1:0]               w_rd_b;

  // Write port: falling-edge commit. Looping over the stored entries keeps
  // a write to address 31 from ever selecting a flop.
  always_ff @(negedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_regs <= '0;
    end else if (RegWr) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (RW == i[4:0]) r_regs[i] <= BusW;
      end
    end
  end

  // Read ports: one-hot compare against stored entries only, so address 31
  // matches nothing and falls through to the zero default.
  always_comb begin
    w_rd_a = '0;
    w_rd_b = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (RA == i[4:0]) w_rd_a = r_regs[i];
      if (RB == i[4:0]) w_rd_b = r_regs[i];
    end
  end

  assign BusA = w_rd_a;
  assign BusB = w_rd_b;

endmodule

// File: tb/tb_register_file.sv
`timescale 1ns/1ps
module tb_register_file;

  logic        Clk;
  logic        Rst_n;
  logic [4:0]  RA, RB, RW;
  logic [63:0] BusW;
  logic        RegWr;
  logic [63:0] BusA, BusB;

  int checks;
  int errors;

  // Reference: plain array of 32 values, entry 31 forced to zero on read.
  logic [63:0] model [32];

  typedef struct {
    logic [4:0]  ra, rb, rw;
    logic [63:0] busw;
    logic        regwr;
    logic [63:0] pre_a, pre_b;
    logic [63:0] post_a, post_b;
  } vec_t;

  vec_t vecs [8];

  register_file dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .RA    (RA),
    .RB    (RB),
    .RW    (RW),
    .BusW  (BusW),
    .RegWr (RegWr),
    .BusA  (BusA),
    .BusB  (BusB)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [63:0] mread(input logic [4:0] a);
    return (a == 5'd31) ? 64'd0 : model[a];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive after rising edge, check before and after the falling edge.
  task automatic step(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rw,
                      input logic [63:0] busw, input logic regwr,
                      input logic [63:0] pa, input logic [63:0] pb,
                      input logic [63:0] qa, input logic [63:0] qb, input string name);
    @(posedge Clk);
    #1;
    RA = ra; RB = rb; RW = rw; BusW = busw; RegWr = regwr;
    #1;
    chk({name, " preA"}, BusA, pa);
    chk({name, " preB"}, BusB, pb);
    @(negedge Clk);
    #1;
    chk({name, " postA"}, BusA, qa);
    chk({name, " postB"}, BusB, qb);
    if (regwr && rw != 5'd31) model[rw] = busw;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    foreach (model[i]) model[i] = '0;
    Rst_n = 1'b0;
    RA = 5'd5; RB = 5'd30; RW = 5'd0; BusW = '0; RegWr = 1'b0;

    // Reset state
    #2;
    chk("reset A5", BusA, 64'd0);
    chk("reset B30", BusB, 64'd0);
    @(posedge Clk);
    #3 Rst_n = 1'b1;

    // XZR write is discarded
    step(5'd31, 5'd31, 5'd31, 64'h12345678, 1'b1, 0, 0, 0, 0, "xzr");

    // reg[n] = n, one per falling edge
    for (int n = 0; n < 32; n++) begin
      @(posedge Clk); #1;
      RW = n[4:0]; BusW = 64'(n); RegWr = 1'b1;
      @(negedge Clk); #1;
      if (n != 31) model[n] = 64'(n);
    end

    vecs[0] = '{5'd0,  5'd1,  5'd1,  64'h1000,    1'b0, 0,       1,      0,       1};
    vecs[1] = '{5'd2,  5'd3,  5'd1,  64'h1000,    1'b0, 2,       3,      2,       3};
    vecs[2] = '{5'd1,  5'd0,  5'd0,  64'h1000,    1'b1, 1,       0,      1,       64'h1000};
    vecs[3] = '{5'd10, 5'd11, 5'd10, 64'h1010,    1'b1, 10,      11,     64'h1010, 11};
    vecs[4] = '{5'd10, 5'd11, 5'd11, 64'h103000,  1'b1, 64'h1010, 11,    64'h1010, 64'h103000};
    vecs[5] = '{5'd12, 5'd13, 5'd13, 64'hABCD,    1'b1, 64'hC,   64'hD,  64'hC,   64'hABCD};
    vecs[6] = '{5'd14, 5'd14, 5'd14, 64'h9080009, 1'b0, 64'hE,   64'hE,  64'hE,   64'hE};
    vecs[7] = '{5'd31, 5'd0,  5'd31, 64'hFFFF,    1'b1, 0,       64'h1000, 0,     64'h1000};

    for (int v = 0; v < 8; v++)
      step(vecs[v].ra, vecs[v].rb, vecs[v].rw, vecs[v].busw, vecs[v].regwr,
           vecs[v].pre_a, vecs[v].pre_b, vecs[v].post_a, vecs[v].post_b,
           $sformatf("vec%0d", v));

    // Async reset between edges; falling edges under reset with RegWr=1 write nothing
    @(posedge Clk); #1;
    RW = 5'd5; BusW = 64'hDEAD_BEEF; RegWr = 1'b1;
    RA = 5'd5; RB = 5'd10;
    #1;
    chk("prersta", BusA, 64'd5);
    Rst_n = 1'b0;
    #0.5;
    chk("rst imm A", BusA, 64'd0);
    chk("rst imm B", BusB, 64'd0);
    for (int a = 0; a < 32; a++) begin
      RA = a[4:0]; RB = 5'(31 - a);
      #1;
      chk($sformatf("rst A%0d", a), BusA, 64'd0);
      chk($sformatf("rst B%0d", 31 - a), BusB, 64'd0);
    end
    @(negedge Clk); #1;
    @(posedge Clk); #1;
    RegWr = 1'b0;
    Rst_n = 1'b1;
    foreach (model[i]) model[i] = '0;
    RA = 5'd5; RB = 5'd0;
    #1;
    chk("post rst A5", BusA, 64'd0);
    chk("post rst B0", BusB, 64'd0);

    // Randomized against the array model
    for (int k = 0; k < 300; k++) begin
      logic [4:0]  ra, rb, rw;
      logic [63:0] w, pa, pb;
      logic        we;
      ra = 5'($urandom_range(0, 31));
      rb = 5'($urandom_range(0, 31));
      rw = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
      w  = {$urandom, $urandom};
      we = 1'($urandom_range(0, 1));
      pa = mread(ra);
      pb = mread(rb);
      if (we && rw != 5'd31) model[rw] = w;
      step(ra, rb, rw, w, we, pa, pb, mread(ra), mread(rb), $sformatf("rnd%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
